// File: rtl/reg16_skid_stage.sv
// reg16_skid_stage: two-entry elastic register stage with valid/ready handshakes on both sides.
// Sits between datapath stages where the consumer can stall. All state updates on negedge clk.
// Outputs are decoded from registered state only, so there is no combinational path from in_*
// to out_*, or from out_ready to in_ready.
//
// Ports:
//   clk        stage clock (state updates on falling edge)
//   rst        synchronous active-high reset; clears state and both slots
//   flush      synchronous discard of all held words; same-cycle push/pop are ignored
//   in_data    write-side word
//   in_valid   writer offers in_data this cycle
//   in_ready   stage can accept a word (not FULL)
//   out_data   oldest held word (main slot); 0 when empty
//   out_valid  out_data holds a valid word
//   out_ready  reader accepts out_data this cycle
//   occupancy  number of held words: 0, 1 or 2
module reg16_skid_stage #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             push, pop;

  assign in_ready  = (state_q != StFull);
  assign out_valid = (state_q != StEmpty);
  assign out_data  = main_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    occupancy = 2'd0;
    case (state_q)
      StEmpty: occupancy = 2'd0;
      StOne:   occupancy = 2'd1;
      StFull:  occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Flush wins over any handshake in the same cycle: the offered word is dropped.
      state_d = StEmpty;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        StEmpty: begin
          if (push) begin
            state_d = StOne;
            main_d  = in_data;
          end
        end
        StOne: begin
          if (push && !pop) begin
            state_d = StFull;
            skid_d  = in_data;
          end else if (!push && pop) begin
            state_d = StEmpty;
            main_d  = '0;
          end else if (push && pop) begin
            // Simultaneous accept and deliver keeps one word per cycle flowing.
            main_d = in_data;
          end
        end
        StFull: begin
          // in_ready is low here, so only a pop can happen.
          if (pop) begin
            state_d = StOne;
            main_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = StEmpty;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule
